// File: rtl/slc3_input_conditioner.sv
// SLC-3 input conditioner: synchronises the raw board inputs and debounces the
// active-low Run/Continue buttons. Each button produces a level output and a
// one-cycle press strobe. Switches are synchronised only.

module slc3_button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Key_n,
   output logic Level,
   output logic Pulse
);

   localparam logic [1:0] RELEASED     = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic [1:0]       state_r;
   logic [1:0]       state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             pulse_s;
   logic             level_s;
   logic             level_r;
   logic             pulse_r;

   // Two-flop synchroniser; reset to the released (high) level
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= Key_n;
         sync2_r <= sync1_r;
      end
   end

   // Debounce next-state: a change is accepted only after the synchronised
   // input holds its new value for the full debounce window
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      pulse_s = 1'b0;
      case (state_r)
         RELEASED: begin
            if (!sync2_r) begin
               state_s = PRESS_WAIT;
               cnt_s   = CNT_ONE;
            end else begin
               cnt_s   = CNT_ZERO;
            end
         end
         PRESS_WAIT: begin
            if (sync2_r) begin
               state_s = RELEASED;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               state_s = PRESSED;
               cnt_s   = CNT_ZERO;
               pulse_s = 1'b1;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         PRESSED: begin
            if (sync2_r) begin
               state_s = RELEASE_WAIT;
               cnt_s   = CNT_ONE;
            end else begin
               cnt_s   = CNT_ZERO;
            end
         end
         RELEASE_WAIT: begin
            if (!sync2_r) begin
               state_s = PRESSED;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               state_s = RELEASED;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = RELEASED;
            cnt_s   = CNT_ZERO;
         end
      endcase
      level_s = (state_s == PRESSED) || (state_s == RELEASE_WAIT);
   end

   // State, counter and registered level/pulse outputs
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_r <= RELEASED;
         cnt_r   <= CNT_ZERO;
         level_r <= 1'b0;
         pulse_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         level_r <= level_s;
         pulse_r <= pulse_s;
      end
   end

   assign Level = level_r;
   assign Pulse = pulse_r;

endmodule

module slc3_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
   parameter int N_SW            = 10
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            KEY_Run_n,
   input  logic            KEY_Continue_n,
   input  logic [N_SW-1:0] SW_raw,
   output logic            Run,
   output logic            Continue,
   output logic            Run_pulse,
   output logic            Continue_pulse,
   output logic [N_SW-1:0] SW
);

   logic [N_SW-1:0] sw_sync1_r;
   logic [N_SW-1:0] sw_sync2_r;

   // Two-flop synchroniser for the slide switches, no debounce
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         sw_sync1_r <= {N_SW{1'b0}};
         sw_sync2_r <= {N_SW{1'b0}};
      end else begin
         sw_sync1_r <= SW_raw;
         sw_sync2_r <= sw_sync1_r;
      end
   end

   assign SW = sw_sync2_r;

   slc3_button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_run (
      .Clk   (Clk),
      .Reset (Reset),
      .Key_n (KEY_Run_n),
      .Level (Run),
      .Pulse (Run_pulse)
   );

   slc3_button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_continue (
      .Clk   (Clk),
      .Reset (Reset),
      .Key_n (KEY_Continue_n),
      .Level (Continue),
      .Pulse (Continue_pulse)
   );

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// Directed self-checking bench for slc3_input_conditioner with a short
// debounce window. Inputs change and outputs are sampled on the falling edge.

module tb_slc3_input_conditioner;

   localparam int D    = 4;
   localparam int N_SW = 10;

   logic            Clk;
   logic            Reset;
   logic            KEY_Run_n;
   logic            KEY_Continue_n;
   logic [N_SW-1:0] SW_raw;
   logic            Run;
   logic            Continue;
   logic            Run_pulse;
   logic            Continue_pulse;
   logic [N_SW-1:0] SW;

   int n_cmp;
   int n_err;

   slc3_input_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .N_SW            (N_SW)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .KEY_Run_n      (KEY_Run_n),
      .KEY_Continue_n (KEY_Continue_n),
      .SW_raw         (SW_raw),
      .Run            (Run),
      .Continue       (Continue),
      .Run_pulse      (Run_pulse),
      .Continue_pulse (Continue_pulse),
      .SW             (SW)
   );

   // Free-running 10-unit clock
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, landing on the following falling edge
   task automatic step(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic check_btn(input string tag, input logic run, input logic cont,
                            input logic rp, input logic cp);
      check_eq({tag, "_run"},   {31'd0, Run},            {31'd0, run});
      check_eq({tag, "_cont"},  {31'd0, Continue},       {31'd0, cont});
      check_eq({tag, "_rpul"},  {31'd0, Run_pulse},      {31'd0, rp});
      check_eq({tag, "_cpul"},  {31'd0, Continue_pulse}, {31'd0, cp});
   endtask

   initial begin
      int pulses;
      n_cmp = 0;
      n_err = 0;
      Reset          = 1'b0;
      KEY_Run_n      = 1'b0;
      KEY_Continue_n = 1'b1;
      SW_raw         = 10'h000;
      @(negedge Clk);

      // 1: reset held with Run pressed, then press accepted on 6th edge
      step(3);
      check_btn("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_sw", {22'd0, SW}, 32'h0);
      Reset = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         step(1);
         check_btn("t1_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      step(1);
      check_btn("t1_acc", 1'b1, 1'b0, 1'b1, 1'b0);

      // 2: keep holding (50 cycles total) -> level stays high, no extra pulse
      pulses = 0;
      for (int e = 7; e <= 50; e++) begin
         step(1);
         check_eq("t2_hold_run", {31'd0, Run}, 32'd1);
         pulses += int'(Run_pulse);
      end
      check_eq("t2_hold_pulses", pulses, 32'd0);
      KEY_Run_n = 1'b1;
      pulses = 0;
      for (int e = 1; e <= 5; e++) begin
         step(1);
         check_eq("t2_rel_wait", {31'd0, Run}, 32'd1);
         pulses += int'(Run_pulse);
      end
      step(1);
      check_eq("t2_rel_done", {31'd0, Run}, 32'd0);
      pulses += int'(Run_pulse);
      check_eq("t2_rel_pulses", pulses, 32'd0);
      step(3);

      // 3: Continue bounce low3 / high1 / low3 / high -> never accepted
      pulses = 0;
      for (int e = 0; e < 16; e++) begin
         KEY_Continue_n = (e < 3 || (e >= 4 && e < 7)) ? 1'b0 : 1'b1;
         step(1);
         check_eq("t3_bounce_lvl", {31'd0, Continue}, 32'd0);
         pulses += int'(Continue_pulse);
      end
      check_eq("t3_bounce_pulses", pulses, 32'd0);
      // Bounce left it RELEASED: a clean press still takes the full window
      KEY_Continue_n = 1'b0;
      step(5);
      check_btn("t3_after_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      step(1);
      check_btn("t3_after_acc", 1'b0, 1'b1, 1'b0, 1'b1);
      KEY_Continue_n = 1'b1;
      step(8);
      check_btn("t3_released", 1'b0, 1'b0, 1'b0, 1'b0);

      // 4: both keys pressed together -> simultaneous pulses
      KEY_Run_n      = 1'b0;
      KEY_Continue_n = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         step(1);
         check_btn("t4_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      step(1);
      check_btn("t4_acc", 1'b1, 1'b1, 1'b1, 1'b1);
      step(1);
      check_btn("t4_post", 1'b1, 1'b1, 1'b0, 1'b0);
      KEY_Run_n      = 1'b1;
      KEY_Continue_n = 1'b1;
      step(8);
      check_btn("t4_released", 1'b0, 1'b0, 1'b0, 1'b0);

      // 5: reset in PRESS_WAIT (cnt=2) discards the count
      KEY_Run_n = 1'b0;
      step(4);
      check_btn("t5_pre", 1'b0, 1'b0, 1'b0, 1'b0);
      Reset = 1'b0;
      step(1);
      check_btn("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      Reset = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         step(1);
         check_btn("t5_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      step(1);
      check_btn("t5_acc", 1'b1, 1'b0, 1'b1, 1'b0);
      KEY_Run_n = 1'b1;
      step(8);

      // 6: switches follow after exactly two edges; reset clears them
      SW_raw = 10'h2A5;
      step(1);
      check_eq("t6_sw_e1", {22'd0, SW}, 32'h000);
      step(1);
      check_eq("t6_sw_e2", {22'd0, SW}, 32'h2A5);
      SW_raw = 10'h15A;
      step(1);
      check_eq("t6_sw_e3", {22'd0, SW}, 32'h2A5);
      step(1);
      check_eq("t6_sw_e4", {22'd0, SW}, 32'h15A);
      Reset = 1'b0;
      step(1);
      check_eq("t6_sw_rst", {22'd0, SW}, 32'h000);
      Reset = 1'b1;
      step(2);
      check_eq("t6_sw_back", {22'd0, SW}, 32'h15A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/slc3_input_conditioner.md
Name: slc3_input_conditioner

Overview:
Upstream front end for the SLC-3 top level. Conditions the raw asynchronous board inputs before they reach the CPU: the active-low Run and Continue push-buttons and the 10 slide switches. Buttons get 2-FF synchronisation, per-button debounce and a rising-edge pulse. Switches get 2-FF synchronisation only. Outputs drive the CPU's Run, Continue and SW inputs directly.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles required to accept a button change (10 ms at 50 MHz); legal range is 2 or more.
CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width.
N_SW, 10, number of switch bits.

Ports:
Clk  in  1  system clock; all flops are on its rising edge.
Reset  in  1  synchronous, active-low reset; Reset=0 at a rising edge of Clk resets the block.
KEY_Run_n  in  1  raw Run button, asynchronous, 0 = pressed.
KEY_Continue_n  in  1  raw Continue button, asynchronous, 0 = pressed.
SW_raw  in  N_SW  raw slide switches, asynchronous.
Run  out  1  debounced Run level, 1 = pressed.
Continue  out  1  debounced Continue level, 1 = pressed.
Run_pulse  out  1  one-cycle strobe on the accepted Run press.
Continue_pulse  out  1  one-cycle strobe on the accepted Continue press.
SW  out  N_SW  synchronised switch values.

Behaviour:
- Reset (Reset=0 at a Clk edge):
  - button sync flops set to 1 (released);
  - switch sync flops set to 0;
  - debounce counters set to 0; button state set to RELEASED;
  - Run, Continue, Run_pulse, Continue_pulse, SW all 0.
- Reset mid-count discards the count. After reset is released, a held button needs the full 2+DEBOUNCE_CYCLES cycles again.
- Synchroniser: s1 <= raw; s2 <= s1. Only s2 feeds downstream logic.
- Per-button FSM, two buttons fully independent instances. States:
  - RELEASED: stable = 0.
  - PRESS_WAIT: s2 = 0 seen, counting.
  - PRESSED: stable = 1.
  - RELEASE_WAIT: s2 = 1 seen, counting.
- Transitions:
  - RELEASED -> PRESS_WAIT when s2 = 0; cnt <= 1.
  - PRESS_WAIT with s2 = 0 and cnt = DEBOUNCE_CYCLES-1 -> PRESSED, cnt <= 0, pulse <= 1 for exactly one cycle.
  - PRESS_WAIT with s2 = 0 otherwise: cnt <= cnt+1.
  - PRESS_WAIT with s2 = 1 (bounce) -> RELEASED, cnt <= 0, no pulse.
  - PRESSED / RELEASE_WAIT are symmetric with s2 = 1. Release produces no pulse. Bounce returns to PRESSED.
- Level output is registered: 1 in PRESSED and RELEASE_WAIT, 0 in RELEASED and PRESS_WAIT.
- Latency: raw falls and stays low before edge k, so s2 = 0 after edge k+1. Run rises after edge k+1+DEBOUNCE_CYCLES, and Run_pulse is high for that same single cycle. Release latency is identical.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Holding a button indefinitely gives exactly one pulse. A new pulse requires an accepted release, then an accepted press.
- Both buttons accepted on the same edge: both pulses assert in the same cycle. There is no priority.
- Switches: SW = two-flop delayed SW_raw, latency 2 edges, no debounce. Bit-independent; a bit changing asynchronously may resolve either way for one cycle.

Test Plan:
1. DEBOUNCE_CYCLES=4, Reset=0 for 3 cycles with KEY_Run_n=0 -> all outputs 0 during reset. Release reset -> Run rises on the 6th edge after release, Run_pulse high 1 cycle.
2. KEY_Run_n=0 held 50 cycles (D=4) -> Run=1 from edge 6 onward; exactly one Run_pulse. Release -> Run=0 after edge 6 post-release, no pulse.
3. Bounce: KEY_Continue_n low 3 cycles, high 1, low 3, high (D=4) -> Continue stays 0, no pulse, FSM returns to RELEASED.
4. Both keys pressed on the same edge (D=4) -> Run_pulse and Continue_pulse both high in the same cycle, 6 edges later.
5. Reset asserted while Run is in PRESS_WAIT with cnt=2, key still held -> after reset release, Run rises only 2+4 edges later.
6. SW_raw 0x000 -> 0x2A5 -> SW=0x2A5 after exactly 2 edges. Reset -> SW=0x000 at the next edge.
